// File: rtl/filter_decimator.sv
// Boxcar decimator for the Q8.8 IIR output stream.
// Each block of DECIM valid samples is averaged and queued in a small FIFO.
module filter_decimator #(
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              in,
    input  logic                     in_valid,
    output logic [15:0]              out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int SH = $clog2(DECIM);
    localparam int AW = 16 + SH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic [SH-1:0]        phase;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [15:0]          mem [DEPTH];
    logic [15:0]          result;
    logic                 last;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 accept;

    assign sum    = acc + {{SH{in[15]}}, in};
    assign result = 16'(sum >>> SH);
    assign last   = (phase == SH'(DECIM - 1));
    assign push   = in_valid && last;
    assign out_valid = (count != '0);
    assign pop    = out_valid && out_ready;
    assign full   = (count == CW'(DEPTH));
    // A full FIFO still takes the new result if the head leaves this cycle.
    assign accept = push && (!full || pop);
    assign out    = out_valid ? mem[rd_ptr] : 16'h0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            phase <= '0;
        end else if (in_valid) begin
            if (last) begin
                acc   <= '0;
                phase <= '0;
            end else begin
                acc   <= sum;
                phase <= phase + SH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= result;
        end
    end
endmodule

// File: tb/tb_filter_decimator.sv
// Bench for filter_decimator: queue-based reference model checked every
// cycle, plus directed vectors with literal expected values.
module tb_filter_decimator;
    localparam int DECIM = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in;
    logic        in_valid;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    filter_decimator #(.DECIM(DECIM), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: block samples as integers, FIFO as a queue.
    int          blk[$];
    logic [15:0] mq[$];
    bit          m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            blk.delete();
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            bit          do_pop;
            bit          do_push;
            int          total;
            logic [15:0] res;
            do_pop  = (mq.size() > 0) && out_ready;
            do_push = 1'b0;
            res     = '0;
            if (in_valid) begin
                blk.push_back(int'($signed(in)));
                if (blk.size() == DECIM) begin
                    total = 0;
                    foreach (blk[i]) total += blk[i];
                    res = 16'(total >>> $clog2(DECIM));
                    blk.delete();
                    do_push = 1'b1;
                end
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                if (mq.size() < DEPTH) mq.push_back(res);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e_out;
        e_out = (mq.size() > 0) ? mq[0] : 16'h0000;
        check("model_out", out, e_out);
        check("model_out_valid", 16'(out_valid), 16'(mq.size() > 0));
        check("model_count", 16'(count), 16'(mq.size()));
        check("model_overflow", 16'(overflow), 16'(m_ovf));
    end

    // Apply one cycle of input, return at the following negedge.
    task automatic drive(logic v, logic [15:0] d);
        in_valid = v;
        in       = d;
        @(negedge clk);
    endtask

    task automatic block4(logic [15:0] d);
        for (int i = 0; i < 4; i++) drive(1'b1, d);
    endtask

    initial begin
        rst       = 1'b1;
        in        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out", out, 16'h0000);
        check("rst_valid", 16'(out_valid), 16'h0000);
        check("rst_count", 16'(count), 16'h0000);
        check("rst_ovf", 16'(overflow), 16'h0000);
        rst = 1'b0;

        // Constant stream: one output per 4 inputs, count toggles.
        for (int b = 0; b < 2; b++) begin
            block4(16'h0100);
            check("const_out", out, 16'h0100);
            check("const_count", 16'(count), 16'h0001);
        end
        drive(1'b0, 16'h0000);
        check("const_drained", 16'(count), 16'h0000);

        block4(16'hFFFF);
        check("neg_one", out, 16'hFFFF);
        drive(1'b0, 16'h0000);
        drive(1'b1, 16'h0001);
        drive(1'b1, 16'h0000);
        drive(1'b1, 16'h0000);
        drive(1'b1, 16'h0000);
        check("trunc_out", out, 16'h0000);
        check("trunc_valid", 16'(out_valid), 16'h0001);
        drive(1'b0, 16'h0000);
        block4(16'h7FFF);
        check("max_pos", out, 16'h7FFF);
        drive(1'b0, 16'h0000);
        block4(16'h8000);
        check("max_neg", out, 16'h8000);
        drive(1'b0, 16'h0000);

        // Gapped input: invalid-cycle values ignored.
        drive(1'b1, 16'h0100);
        drive(1'b0, 16'hDEAD);
        drive(1'b0, 16'hBEEF);
        drive(1'b1, 16'h0200);
        drive(1'b0, 16'h1234);
        drive(1'b1, 16'h0300);
        check("gap_pending", 16'(out_valid), 16'h0000);
        drive(1'b1, 16'h0400);
        check("gap_out", out, 16'h0280);
        drive(1'b0, 16'h0000);

        // Full FIFO, completing block with a simultaneous pop.
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) block4(16'(k << 8));
        check("full_count", 16'(count), 16'h0004);
        for (int i = 0; i < 3; i++) drive(1'b1, 16'h0500);
        out_ready = 1'b1;
        drive(1'b1, 16'h0500);
        check("swap_count", 16'(count), 16'h0004);
        check("swap_ovf", 16'(overflow), 16'h0000);
        check("swap_head", out, 16'h0200);
        for (int k = 2; k <= 5; k++) begin
            check("swap_drain", out, 16'(k << 8));
            drive(1'b0, 16'h0000);
        end
        check("swap_empty", 16'(count), 16'h0000);

        // Overflow: fifth block dropped.
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) block4(16'(k << 8));
        check("pre_ovf", 16'(overflow), 16'h0000);
        block4(16'h0500);
        check("ovf_set", 16'(overflow), 16'h0001);
        check("ovf_count", 16'(count), 16'h0004);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("ovf_drain", out, 16'(k << 8));
            drive(1'b0, 16'h0000);
        end
        check("ovf_empty", 16'(count), 16'h0000);
        check("ovf_sticky", 16'(overflow), 16'h0001);

        // Reset mid-block with two queued entries.
        out_ready = 1'b0;
        block4(16'h0100);
        block4(16'h0100);
        drive(1'b1, 16'h0700);
        drive(1'b1, 16'h0700);
        check("pre_rst_count", 16'(count), 16'h0002);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_valid", 16'(out_valid), 16'h0000);
        check("async_count", 16'(count), 16'h0000);
        check("async_ovf", 16'(overflow), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        block4(16'h0100);
        check("post_rst_out", out, 16'h0100);
        check("post_rst_count", 16'(count), 16'h0001);
        drive(1'b0, 16'h0000);
        drive(1'b0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
